ltc2308_adc_scanner: RTL and testbench

- Source side of the eight 64-bit ADC export words that the HPS reads through the SoC system (adc0_export..adc7_export).
- Drives the on-board LTC2308 8-channel 12-bit SPI ADC.
- Scans channels 0..7 round-robin, single-ended and unipolar.
- Packs each result with a sequence count and the previous sample into that channel's 64-bit word.
- Sits in the FPGA top level between the ADC pins and the soc_system ADC inputs.

---
 rtl/ltc2308_adc_scanner_if.sv | 10 +
 rtl/ltc2308_adc_scanner.sv | 177 +++++++++++++++++
 tb/tb_ltc2308_adc_scanner.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ltc2308_adc_scanner_if.sv
// LTC2308 convert/SPI pin bundle: the scanner is the master, the ADC the slave.
interface ltc2308_adc_scanner_if;
    logic adc_convst;
    logic adc_sck;
    logic adc_sdi;
    logic adc_sdo;

    modport master (output adc_convst, output adc_sck, output adc_sdi, input adc_sdo);
    modport slave  (input adc_convst, input adc_sck, input adc_sdi, output adc_sdo);
endinterface

// File: rtl/ltc2308_adc_scanner.sv
// Round-robin LTC2308 scanner: converts channels 0..7 and packs each result with an
// update count and the previous sample into that channel's 64-bit export word.
module ltc2308_adc_scanner #(
    parameter int unsigned CONV_CYCLES = 80,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  enable,
    ltc2308_adc_scanner_if.master adc,
    output logic [63:0]           adc0_export,
    output logic [63:0]           adc1_export,
    output logic [63:0]           adc2_export,
    output logic [63:0]           adc3_export,
    output logic [63:0]           adc4_export,
    output logic [63:0]           adc5_export,
    output logic [63:0]           adc6_export,
    output logic [63:0]           adc7_export,
    output logic                  sample_valid,
    output logic [2:0]            sample_ch
);
    localparam int unsigned CNT_MAX = (CONV_CYCLES > GAP_CYCLES) ? CONV_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned DIV_W   = $clog2(2 * CLK_DIV) + 1;
    localparam int unsigned RES_W   = 12;
    localparam int unsigned BITS    = 12;
    localparam int unsigned CFG_W   = 6;
    localparam int unsigned CH_W    = 3;
    localparam int unsigned BIT_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_ACQ,
        S_SHIFT,
        S_UPDATE,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [BIT_W-1:0]   r_bit;
    logic [CH_W-1:0]    r_ch;
    logic [CH_W-1:0]    r_res_ch;
    logic               r_first;
    logic [CFG_W-1:0]   r_cfg;
    logic [RES_W-1:0]   r_shift;
    logic               r_convst;
    logic               r_sck;
    logic               r_sdi;
    logic               r_valid;
    logic [CH_W-1:0]    r_sample_ch;
    logic [7:0][63:0]   r_exp;

    logic [CFG_W-1:0]   w_cfg;
    logic [31:0]        w_old_cnt;
    logic [RES_W-1:0]   w_old_smp;

    // Single-ended, unipolar, awake: {S/D, O/S, S1, S0, UNI, SLP}
    assign w_cfg     = {1'b1, r_ch[0], r_ch[2], r_ch[1], 1'b1, 1'b0};
    assign w_old_cnt = r_exp[r_res_ch][63:32];
    assign w_old_smp = r_exp[r_res_ch][11:0];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_div       <= '0;
            r_bit       <= '0;
            r_ch        <= '0;
            r_res_ch    <= '0;
            r_first     <= 1'b1;
            r_cfg       <= '0;
            r_shift     <= '0;
            r_convst    <= 1'b0;
            r_sck       <= 1'b0;
            r_sdi       <= 1'b0;
            r_valid     <= 1'b0;
            r_sample_ch <= '0;
            r_exp       <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_convst <= 1'b0;
                    r_sck    <= 1'b0;
                    r_sdi    <= 1'b0;
                    if (enable) begin
                        r_state  <= S_CONV;
                        r_convst <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                S_CONV: begin
                    if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
                        r_state  <= S_ACQ;
                        r_convst <= 1'b0;
                        r_sdi    <= w_cfg[CFG_W-1];
                        r_cfg    <= {w_cfg[CFG_W-2:0], 1'b0};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ACQ: begin
                    r_state <= S_SHIFT;
                    r_div   <= '0;
                    r_bit   <= '0;
                end
                S_SHIFT: begin
                    // SDO is captured on the clock that raises SCK
                    if (r_div == DIV_W'(CLK_DIV - 1)) begin
                        r_sck   <= 1'b1;
                        r_shift <= {r_shift[RES_W-2:0], adc.adc_sdo};
                    end
                    if (r_div == DIV_W'(2 * CLK_DIV - 1)) begin
                        r_sck <= 1'b0;
                        r_div <= '0;
                        if (r_bit == BIT_W'(BITS - 1)) begin
                            r_state <= S_UPDATE;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                            r_sdi <= r_cfg[CFG_W-1];
                            r_cfg <= {r_cfg[CFG_W-2:0], 1'b0};
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_UPDATE: begin
                    // Result belongs to the config sent in the previous frame
                    if (!r_first) begin
                        r_exp[r_res_ch] <= {w_old_cnt + 32'd1, 4'h0, w_old_smp, 4'h0, r_shift};
                        r_valid         <= 1'b1;
                        r_sample_ch     <= r_res_ch;
                    end
                    r_first  <= 1'b0;
                    r_res_ch <= r_ch;
                    r_ch     <= r_ch + CH_W'(1);
                    r_state  <= S_GAP;
                    r_cnt    <= '0;
                end
                S_GAP: begin
                    if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        r_cnt <= '0;
                        if (enable) begin
                            r_state  <= S_CONV;
                            r_convst <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign adc.adc_convst = r_convst;
    assign adc.adc_sck    = r_sck;
    assign adc.adc_sdi    = r_sdi;
    assign sample_valid   = r_valid;
    assign sample_ch      = r_sample_ch;
    assign adc0_export    = r_exp[0];
    assign adc1_export    = r_exp[1];
    assign adc2_export    = r_exp[2];
    assign adc3_export    = r_exp[3];
    assign adc4_export    = r_exp[4];
    assign adc5_export    = r_exp[5];
    assign adc6_export    = r_exp[6];
    assign adc7_export    = r_exp[7];
endmodule

// File: tb/tb_ltc2308_adc_scanner.sv
// Bench for ltc2308_adc_scanner: behavioural LTC2308 plus a per-channel export model.
module tb_ltc2308_adc_scanner;
    localparam int FRAME      = 134;
    // First strobe lands at the end of the second frame's UPDATE (frame 0 only primes)
    localparam int FIRST_LAT  = FRAME + 131;
    localparam int RESUME_LAT = 131;

    logic        clk_clk     = 1'b0;
    logic        reset_reset = 1'b1;
    logic        enable      = 1'b0;
    logic [63:0] ex [8];
    logic        sample_valid;
    logic [2:0]  sample_ch;

    ltc2308_adc_scanner_if adc_if ();

    ltc2308_adc_scanner dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .enable      (enable),
        .adc         (adc_if),
        .adc0_export (ex[0]),
        .adc1_export (ex[1]),
        .adc2_export (ex[2]),
        .adc3_export (ex[3]),
        .adc4_export (ex[4]),
        .adc5_export (ex[5]),
        .adc6_export (ex[6]),
        .adc7_export (ex[7]),
        .sample_valid(sample_valid),
        .sample_ch   (sample_ch)
    );

    always #10 clk_clk = ~clk_clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk_clk) cyc <= cyc + 1;

    // ---------------- behavioural LTC2308 ----------------
    int          mode      = 0;
    int          conv_seq  = 0;
    logic [11:0] conv_val  = '0;
    logic [11:0] adc_sreg  = '0;
    logic [5:0]  cfg_sr    = '0;
    int          cfg_bits  = 0;
    logic [2:0]  cfg_ch    = '0;
    logic [5:0]  cfg_log [$];

    always @(posedge adc_if.adc_convst) begin
        conv_seq = conv_seq + 1;
        cfg_bits = 0;
        case (mode)
            0:       conv_val = 12'hA5C;
            1:       conv_val = 12'(int'(cfg_ch) * 256 + (conv_seq & 255));
            default: conv_val = 12'($urandom_range(0, 4095));
        endcase
    end

    always @(negedge adc_if.adc_convst) adc_sreg = conv_val;
    always @(negedge adc_if.adc_sck)    adc_sreg = {adc_sreg[10:0], 1'b0};

    always @(posedge adc_if.adc_sck) begin
        if (cfg_bits < 6) begin
            cfg_sr   = {cfg_sr[4:0], adc_if.adc_sdi};
            cfg_bits = cfg_bits + 1;
            if (cfg_bits == 6) begin
                cfg_log.push_back(cfg_sr);
                cfg_ch = {cfg_sr[3], cfg_sr[2], cfg_sr[4]};
            end
        end
    end

    assign adc_if.adc_sdo = adc_sreg[11];

    // ---------------- SPI timing monitor ----------------
    logic sck_d = 1'b0, sdi_d = 1'b0, cv_d = 1'b0;
    int   hi_run = 0, lo_run = 0, cv_run = 0, frm_rises = 0;
    int   last_rises = 0, last_cv_len = 0, bad_hi = 0, bad_lo = 0, bad_sdi = 0;
    int   n_strobes = 0;

    always @(negedge clk_clk) begin
        sck_d <= adc_if.adc_sck;
        sdi_d <= adc_if.adc_sdi;
        cv_d  <= adc_if.adc_convst;
        if (adc_if.adc_sck) hi_run <= sck_d ? hi_run + 1 : 1;
        else                lo_run <= sck_d ? 1 : lo_run + 1;
        if (adc_if.adc_sck && !sck_d) begin
            frm_rises <= frm_rises + 1;
            if (frm_rises > 0 && lo_run != 2) bad_lo <= bad_lo + 1;
            if (adc_if.adc_sdi !== sdi_d) bad_sdi <= bad_sdi + 1;
        end
        if (!adc_if.adc_sck && sck_d && hi_run != 2) bad_hi <= bad_hi + 1;
        if (adc_if.adc_convst) cv_run <= cv_d ? cv_run + 1 : 1;
        if (adc_if.adc_convst && !cv_d) begin
            last_rises <= frm_rises;
            frm_rises  <= 0;
        end
        if (!adc_if.adc_convst && cv_d) last_cv_len <= cv_run;
        if (sample_valid === 1'b1) n_strobes <= n_strobes + 1;
    end

    // ---------------- export reference model ----------------
    logic [5:0]       cfg_tbl [8] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                                      6'b101010, 6'b111010, 6'b101110, 6'b111110};
    logic [31:0]      m_cnt  [8];
    logic [11:0]      m_prev [8];
    logic [11:0]      m_last [8];
    int               e_ch  = 0;
    int               t_ref = 0;
    logic [7:0][63:0] fv;

    function automatic logic [63:0] m_word(input int c);
        return {m_cnt[c], 4'h0, m_prev[c], 4'h0, m_last[c]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_cnt[i]  = '0;
            m_prev[i] = '0;
            m_last[i] = '0;
        end
        e_ch = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_strobe(input string tag, input int gap);
        int          n = 0;
        logic [11:0] v;
        while (sample_valid !== 1'b1 && n < 700) begin
            @(negedge clk_clk);
            n++;
        end
        if (sample_valid !== 1'b1) begin
            chk({tag, "_timeout"}, 64'(sample_valid), 64'd1);
        end else begin
            v = (mode == 1) ? 12'(e_ch * 256 + (conv_seq & 255)) : conv_val;
            chk({tag, "_gap"}, 64'(cyc - t_ref), 64'(gap));
            chk({tag, "_ch"}, 64'(sample_ch), 64'(e_ch));
            m_cnt[e_ch]  = m_cnt[e_ch] + 32'd1;
            m_prev[e_ch] = m_last[e_ch];
            m_last[e_ch] = v;
            for (int i = 0; i < 8; i++)
                chk($sformatf("%s_adc%0d", tag, i), ex[i], m_word(i));
            e_ch  = (e_ch + 1) % 8;
            t_ref = cyc;
            @(negedge clk_clk);
        end
    endtask

    task automatic wait_sck_high(input string tag);
        int n = 0;
        while (adc_if.adc_sck !== 1'b1 && n < 400) begin
            @(negedge clk_clk);
            n++;
        end
        chk(tag, 64'(adc_if.adc_sck), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   k0;
        int   ns;
        logic act;
        model_reset();
        repeat (3) @(negedge clk_clk);
        chk("rst_convst", 64'(adc_if.adc_convst), 64'd0);
        chk("rst_sck",    64'(adc_if.adc_sck),    64'd0);
        chk("rst_sdi",    64'(adc_if.adc_sdi),    64'd0);
        chk("rst_valid",  64'(sample_valid),      64'd0);
        chk("rst_ch",     64'(sample_ch),         64'd0);
        reset_reset = 1'b0;

        ns  = n_strobes;
        act = 1'b0;
        repeat (100) begin
            @(negedge clk_clk);
            act = act | adc_if.adc_convst | adc_if.adc_sck | adc_if.adc_sdi | sample_valid;
        end
        chk("idle_activity", 64'(act), 64'd0);
        chk("idle_strobes", 64'(n_strobes - ns), 64'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("idle_adc%0d", i), ex[i], 64'd0);

        // Constant 0xA5C conversions
        mode = 0;
        k0 = cfg_log.size();
        enable = 1'b1;
        t_ref = cyc;
        expect_strobe("a5c_first", FIRST_LAT);
        chk("a5c_word", ex[0], 64'h0000_0001_0000_0A5C);
        chk("a5c_cfg0", 64'(cfg_log[k0]), 64'(6'b100010));
        chk("a5c_cfg1", 64'(cfg_log[k0 + 1]), 64'(6'b110010));
        expect_strobe("a5c_next", FRAME);

        // Channel-coded conversions over 17 frames
        enable = 1'b0;
        reset_reset = 1'b1;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        model_reset();
        mode = 1;
        k0 = cfg_log.size();
        enable = 1'b1;
        t_ref = cyc;
        expect_strobe("seq_first", FIRST_LAT);
        repeat (15) expect_strobe("seq", FRAME);
        chk("seq_adc0_cnt", 64'(ex[0][63:32]), 64'd2);
        chk("seq_adc7_tag", 64'(ex[7][11:8]), 64'd7);
        for (int i = 0; i < 17; i++)
            chk($sformatf("seq_cfg%0d", i), 64'(cfg_log[k0 + i]), 64'(cfg_tbl[i % 8]));
        chk("spi_rises",   64'(last_rises),  64'd12);
        chk("spi_convst",  64'(last_cv_len), 64'd80);
        chk("spi_high",    64'(bad_hi),      64'd0);
        chk("spi_low",     64'(bad_lo),      64'd0);
        chk("spi_sdi",     64'(bad_sdi),     64'd0);

        // Random conversions, then drop enable mid-SHIFT and resume
        mode = 2;
        repeat (3) expect_strobe("rnd", FRAME);
        wait_sck_high("drop_in_shift");
        enable = 1'b0;
        expect_strobe("drop", FRAME);
        ns = n_strobes;
        repeat (300) @(negedge clk_clk);
        chk("drop_idle_strobes", 64'(n_strobes - ns), 64'd0);
        chk("drop_idle_convst", 64'(adc_if.adc_convst), 64'd0);
        k0 = cfg_log.size();
        enable = 1'b1;
        t_ref = cyc;
        expect_strobe("resume", RESUME_LAT);
        chk("resume_cfg", 64'(cfg_log[k0]), 64'(cfg_tbl[e_ch]));

        // Reset in the middle of SHIFT
        wait_sck_high("rst_in_shift");
        reset_reset = 1'b1;
        @(negedge clk_clk);
        chk("mrst_convst", 64'(adc_if.adc_convst), 64'd0);
        chk("mrst_sck",    64'(adc_if.adc_sck),    64'd0);
        chk("mrst_sdi",    64'(adc_if.adc_sdi),    64'd0);
        chk("mrst_valid",  64'(sample_valid),      64'd0);
        chk("mrst_ch",     64'(sample_ch),         64'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("mrst_adc%0d", i), ex[i], 64'd0);
        reset_reset = 1'b0;
        model_reset();
        t_ref = cyc;
        expect_strobe("post_rst", FIRST_LAT);
        expect_strobe("post_rst", FRAME);
        expect_strobe("post_rst", FRAME);

        // Count wrap on channel 3
        for (int i = 0; i < 8; i++) fv[i] = m_word(i);
        m_cnt[3] = 32'hFFFF_FFFF;
        fv[3] = m_word(3);
        force dut.r_exp = fv;
        #1;
        release dut.r_exp;
        expect_strobe("wrap", FRAME);
        chk("wrap_cnt", 64'(ex[3][63:32]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
